// File: rtl/niski_lcd_pkg.sv
// Shared definitions for the HD44780 responder: opcode patterns, DDRAM geometry,
// busy FSM states, display-control bits and address-counter helpers.
package niski_lcd_pkg;

  localparam int          DDRAM_DEPTH = 80;
  localparam int          LINE_LEN    = 40;
  localparam logic [6:0]  LINE2_BASE  = 7'h40;
  localparam logic [6:0]  LINE1_LAST  = 7'(LINE_LEN - 1);
  localparam logic [6:0]  LINE2_LAST  = 7'(LINE2_BASE + LINE_LEN - 1);
  localparam logic [6:0]  DDRAM_LAST  = 7'(DDRAM_DEPTH - 1);

  localparam logic [7:0]  OP_CLEAR     = 8'h01;
  localparam logic [7:0]  MASK_HOME    = 8'hFE;
  localparam logic [7:0]  OP_HOME      = 8'h02;
  localparam logic [7:0]  MASK_ENTRY   = 8'hFC;
  localparam logic [7:0]  OP_ENTRY     = 8'h04;
  localparam logic [7:0]  MASK_DISP    = 8'hF8;
  localparam logic [7:0]  OP_DISP      = 8'h08;
  localparam logic [7:0]  MASK_SHIFT   = 8'hF0;
  localparam logic [7:0]  OP_SHIFT     = 8'h10;
  localparam logic [7:0]  MASK_FUNC    = 8'hE0;
  localparam logic [7:0]  OP_FUNC      = 8'h20;
  localparam logic [7:0]  MASK_CGRAM   = 8'hC0;
  localparam logic [7:0]  OP_CGRAM     = 8'h40;
  localparam logic [7:0]  MASK_DDRAM   = 8'h80;
  localparam logic [7:0]  OP_DDRAM     = 8'h80;

  typedef enum logic {ST_IDLE, ST_BUSY} lcd_state_t;

  typedef struct packed {
    logic display;
    logic cursor;
    logic blink;
  } disp_ctrl_t;

  function automatic logic ac_valid(input logic [6:0] ac, input logic two_line);
    if (two_line)
      return (ac <= LINE1_LAST) || ((ac >= LINE2_BASE) && (ac <= LINE2_LAST));
    return ac <= DDRAM_LAST;
  endfunction

  // Line 2 (0x40..0x67) lands directly after line 1 in the linear DDRAM.
  function automatic logic [6:0] ac_index(input logic [6:0] ac, input logic two_line);
    if (two_line && (ac >= LINE2_BASE))
      return ac - LINE2_BASE + 7'(LINE_LEN);
    return ac;
  endfunction

  function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc,
                                         input logic two_line);
    if (!ac_valid(ac, two_line)) return 7'h00;
    if (inc) begin
      if (!two_line) return (ac == DDRAM_LAST) ? 7'h00 : ac + 7'd1;
      if (ac == LINE1_LAST) return LINE2_BASE;
      if (ac == LINE2_LAST) return 7'h00;
      return ac + 7'd1;
    end
    if (!two_line) return (ac == 7'h00) ? DDRAM_LAST : ac - 7'd1;
    if (ac == 7'h00) return LINE2_LAST;
    if (ac == LINE2_BASE) return LINE1_LAST;
    return ac - 7'd1;
  endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: resets and clears to spaces (0x20), one write port,
// combinational read ports for the address counter and the debug index.
module lcd_ddram
  import niski_lcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [6:0] waddr,
  input  logic [7:0] wdata,
  input  logic       clr,
  input  logic [6:0] rd_idx,
  output logic [7:0] rd_data,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char
);

  logic [7:0] mem_q [DDRAM_DEPTH];
  logic [7:0] mem_d [DDRAM_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      for (int i = 0; i < DDRAM_DEPTH; i++) mem_d[i] = 8'h20;
    end else if (we && (waddr <= DDRAM_LAST)) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DDRAM_DEPTH; i++) mem_q[i] <= 8'h20;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads see the registered contents, so a same-cycle write shows next cycle.
  assign rd_data  = (rd_idx   <= DDRAM_LAST) ? mem_q[rd_idx]   : 8'h00;
  assign dbg_char = (dbg_addr <= DDRAM_LAST) ? mem_q[dbg_addr] : 8'h00;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Panel-side HD44780 responder: E-fall execution, address counter, busy FSM.
// LCD_FOUR_BIT_EN enables the 4-bit (DL=0) nibble interface.
module lcd_hd44780_responder
  import niski_lcd_pkg::*;
#(
  parameter int CMD_CYCLES   = 2000,
  parameter int CLEAR_CYCLES = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_char,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       busy,
  output logic       cmd_error
);

  localparam int            CW         = $clog2(CLEAR_CYCLES + 1);
  localparam logic [CW-1:0] CMD_LOAD   = CW'(CMD_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_CYCLES - 1);

  lcd_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          e_q, e_d;
  logic [6:0]    ac_q, ac_d;
  logic          id_q, id_d;
  logic          s_q, s_d;
  logic          dl_q, dl_d;
  logic          n_q, n_d;
  disp_ctrl_t    ctrl_q, ctrl_d;
  logic          ph_q, ph_d;
  logic [3:0]    hi_q, hi_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          oe_q, oe_d;
  logic          cmd_error_q, cmd_error_d;

  logic          four_bit;
  logic          fall;
  logic          last_nibble;
  logic [7:0]    cmd_byte;
  logic [7:0]    rd_byte;
  logic [7:0]    ram_rd;
  logic          ram_we;
  logic          ram_clr;
  logic          unused_bits;

`ifdef LCD_FOUR_BIT_EN
  assign four_bit    = ~dl_q;
  assign unused_bits = s_q;
`else
  // DL is remembered for status purposes only; the bus stays 8 bits wide.
  assign four_bit    = 1'b0;
  assign unused_bits = ^{s_q, dl_q};
`endif

  assign fall        = e_q & ~lcd_e;
  assign last_nibble = ~four_bit | ph_q;
  assign cmd_byte    = four_bit ? {hi_q, lcd_data_in[7:4]} : lcd_data_in;
  assign rd_byte     = lcd_rs ? ram_rd : {state_q == ST_BUSY, ac_q};

  lcd_ddram u_ddram (
    .clk      (clk),
    .rst      (rst),
    .we       (ram_we),
    .waddr    (ac_index(ac_q, n_q)),
    .wdata    (cmd_byte),
    .clr      (ram_clr),
    .rd_idx   (ac_index(ac_q, n_q)),
    .rd_data  (ram_rd),
    .dbg_addr (dbg_addr),
    .dbg_char (dbg_char)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    e_d         = lcd_e;
    ac_d        = ac_q;
    id_d        = id_q;
    s_d         = s_q;
    dl_d        = dl_q;
    n_d         = n_q;
    ctrl_d      = ctrl_q;
    ph_d        = ph_q;
    hi_d        = hi_q;
    cmd_error_d = 1'b0;
    ram_we      = 1'b0;
    ram_clr     = 1'b0;

    oe_d = lcd_e & lcd_rw;
    if (lcd_e && lcd_rw)
      data_out_d = !four_bit ? rd_byte
                 : (ph_q ? {rd_byte[3:0], 4'h0} : {rd_byte[7:4], 4'h0});
    else
      data_out_d = 8'h00;

    if (state_q == ST_BUSY) begin
      if (cnt_q == '0) state_d = ST_IDLE;
      else             cnt_d   = cnt_q - 1'b1;
    end

    if (fall) begin
      if (four_bit) begin
        ph_d = ~ph_q;
        if (!ph_q) hi_d = lcd_data_in[7:4];
      end
      if (last_nibble) begin
        if (lcd_rw) begin
          if (lcd_rs) ac_d = ac_step(ac_q, id_q, n_q);
        end else if (state_q == ST_BUSY) begin
          cmd_error_d = 1'b1;
        end else begin
          state_d = ST_BUSY;
          cnt_d   = CMD_LOAD;
          if (lcd_rs) begin
            ram_we = ac_valid(ac_q, n_q);
            ac_d   = ac_step(ac_q, id_q, n_q);
          end else if ((cmd_byte & MASK_DDRAM) == OP_DDRAM) begin
            ac_d = cmd_byte[6:0];
          end else if ((cmd_byte & MASK_CGRAM) == OP_CGRAM) begin
            ac_d = ac_q;
          end else if ((cmd_byte & MASK_FUNC) == OP_FUNC) begin
            dl_d = cmd_byte[4];
            n_d  = cmd_byte[3];
            if (cmd_byte[4]) ph_d = 1'b0;
          end else if ((cmd_byte & MASK_SHIFT) == OP_SHIFT) begin
            if (!cmd_byte[3]) ac_d = ac_step(ac_q, cmd_byte[2], n_q);
          end else if ((cmd_byte & MASK_DISP) == OP_DISP) begin
            ctrl_d = disp_ctrl_t'(cmd_byte[2:0]);
          end else if ((cmd_byte & MASK_ENTRY) == OP_ENTRY) begin
            id_d = cmd_byte[1];
            s_d  = cmd_byte[0];
          end else if ((cmd_byte & MASK_HOME) == OP_HOME) begin
            ac_d  = 7'h00;
            cnt_d = CLEAR_LOAD;
          end else if (cmd_byte == OP_CLEAR) begin
            ram_clr = 1'b1;
            ac_d    = 7'h00;
            id_d    = 1'b1;
            cnt_d   = CLEAR_LOAD;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      e_q         <= 1'b0;
      ac_q        <= 7'h00;
      id_q        <= 1'b1;
      s_q         <= 1'b0;
      dl_q        <= 1'b1;
      n_q         <= 1'b0;
      ctrl_q      <= '0;
      ph_q        <= 1'b0;
      hi_q        <= 4'h0;
      data_out_q  <= 8'h00;
      oe_q        <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      e_q         <= e_d;
      ac_q        <= ac_d;
      id_q        <= id_d;
      s_q         <= s_d;
      dl_q        <= dl_d;
      n_q         <= n_d;
      ctrl_q      <= ctrl_d;
      ph_q        <= ph_d;
      hi_q        <= hi_d;
      data_out_q  <= data_out_d;
      oe_q        <= oe_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign lcd_data_out = data_out_q;
  assign lcd_data_oe  = oe_q;
  assign display_on   = ctrl_q.display;
  assign cursor_on    = ctrl_q.cursor;
  assign blink_on     = ctrl_q.blink;
  assign two_line     = n_q;
  assign busy         = (state_q == ST_BUSY);
  assign cmd_error    = cmd_error_q;

endmodule
